ctrl_pipeline: RTL and testbench

Registered, parametrised decode-and-control pipeline for the core. It decodes each fetched opcode into control bundles for the execute, memory and writeback stages. Two-word instructions are handled by a small state machine that absorbs the following immediate word. The bundles are carried through EX/MEM/WB registers that support stall and flush, so the datapath stage registers no longer have to hold control bits.

---
 rtl/ctrl_pipeline.sv | 248 ++++++++++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Decodes fetched opcodes into control bundles and carries them through
// EX, MEM and WB registers with stall and flush support. Two-word
// instructions (ADDI, LDM, LDD, STD) either absorb the next valid word as
// their immediate (MULTIWORD=1) or take it from imm_in in the same cycle
// (MULTIWORD=0).
//
// Parameters:
//   OPCODE_W  opcode width (>=7); any set bit above bit 6 decodes as NOP
//   IMM_W     immediate width
//   MULTIWORD 1: immediate is the next valid word, 0: immediate on imm_in
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   instr_valid  instr carries a valid word this cycle
//   instr        opcode in [OPCODE_W-1:0] or immediate in [IMM_W-1:0]
//   imm_in       same-cycle immediate (MULTIWORD=0 only)
//   stall        hazard stall
//   flush        taken-branch kill
//   imm_pending  next valid word will be consumed as an immediate
//   id_srcs      {branch[2:0], setC, load}
//   ex_cntrl     {func[2:0], skipE}
//   ex_imm       immediate for EX
//   ex_imm_sel   {imm1, imm2}
//   me_cntrl     {wr, pop, push, skipM}
//   wb_cntrl     skipW
module ctrl_pipeline #(
  parameter int OPCODE_W  = 7,
  parameter int IMM_W     = 16,
  parameter int MULTIWORD = 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                instr_valid,
  input  logic [((OPCODE_W > IMM_W) ? OPCODE_W : IMM_W)-1:0]  instr,
  input  logic [IMM_W-1:0]                                    imm_in,
  input  logic                                                stall,
  input  logic                                                flush,
  output logic                                                imm_pending,
  output logic [4:0]                                          id_srcs,
  output logic [3:0]                                          ex_cntrl,
  output logic [IMM_W-1:0]                                    ex_imm,
  output logic [1:0]                                          ex_imm_sel,
  output logic [3:0]                                          me_cntrl,
  output logic                                                wb_cntrl
);

  // Full control bundle as it leaves decode; the MEM and WB parts ride
  // along in the EX register until their stage picks them up.
  typedef struct packed {
    logic [2:0] branch;
    logic       setc;
    logic       load;
    logic [2:0] func;
    logic       skip_e;
    logic       imm1;
    logic       imm2;
    logic       wr;
    logic       pop;
    logic       push;
    logic       skip_m;
    logic       skip_w;
  } ctrl_t;

  typedef enum logic {
    S_IDLE,
    S_IMM
  } state_t;

  function automatic ctrl_t bubble();
    ctrl_t c;
    c        = '0;
    c.skip_e = 1'b1;
    c.skip_m = 1'b1;
    c.skip_w = 1'b1;
    return c;
  endfunction

  // Opcodes wider than 7 bits are only legal with all upper bits clear.
  function automatic logic upper_clear(input logic [OPCODE_W-1:0] opc);
    return ((opc >> 7) == '0);
  endfunction

  function automatic ctrl_t decode(input logic [OPCODE_W-1:0] opc);
    ctrl_t      c;
    logic [6:0] op;
    c  = bubble();
    op = opc[6:0];
    if (upper_clear(opc)) begin
      casez (op)
        7'b0001100: c.setc = 1'b1;
        7'b0010100: c.skip_e = 1'b1;
        7'b0100???: begin
          c.func   = op[2:0];
          c.skip_e = 1'b0;
          c.skip_w = 1'b0;
        end
        7'b0101000: begin
          c.skip_e = 1'b0;
          c.skip_w = 1'b0;
          c.imm2   = 1'b1;
        end
        7'b0110000: c.skip_w = 1'b0;
        7'b0111000: begin
          c.skip_w = 1'b0;
          c.imm1   = 1'b1;
        end
        7'b1000000: begin
          c.skip_m = 1'b0;
          c.wr     = 1'b1;
          c.push   = 1'b1;
        end
        7'b1001000: begin
          c.skip_m = 1'b0;
          c.pop    = 1'b1;
          c.skip_w = 1'b0;
        end
        7'b1010000: begin
          c.skip_e = 1'b0;
          c.skip_m = 1'b0;
          c.skip_w = 1'b0;
          c.load   = 1'b1;
          c.imm2   = 1'b1;
        end
        7'b1011000: begin
          c.skip_e = 1'b0;
          c.skip_m = 1'b0;
          c.wr     = 1'b1;
          c.imm2   = 1'b1;
        end
        7'b110????: begin
          case (op[3:2])
            2'b00:   c.branch = 3'b101;
            2'b01:   c.branch = 3'b110;
            2'b10:   c.branch = 3'b111;
            default: c.branch = 3'b100;
          endcase
        end
        default: c = bubble();
      endcase
    end
    return c;
  endfunction

  function automatic logic is_two_word(input logic [OPCODE_W-1:0] opc);
    logic [6:0] op;
    op = opc[6:0];
    return upper_clear(opc) &&
           (op == 7'b0101000 || op == 7'b0111000 ||
            op == 7'b1010000 || op == 7'b1011000);
  endfunction

  state_t           state_q, state_next;
  ctrl_t            latch_q, latch_next;
  ctrl_t            ex_q, ex_next;
  logic [IMM_W-1:0] ex_imm_q, ex_imm_next;
  logic [3:0]       me_q, me_next;
  logic             me_skip_w_q, me_skip_w_next;
  logic             wb_q, wb_next;

  ctrl_t            dec;
  logic             dec_two;

  // Next-state and next-stage logic. Flush beats stall for EX and the FSM,
  // but a stall still forces a bubble into MEM whatever flush does.
  always_comb begin
    dec            = decode(instr[OPCODE_W-1:0]);
    dec_two        = is_two_word(instr[OPCODE_W-1:0]);
    state_next     = state_q;
    latch_next     = latch_q;
    ex_next        = ex_q;
    ex_imm_next    = ex_imm_q;
    me_next        = {ex_q.wr, ex_q.pop, ex_q.push, ex_q.skip_m};
    me_skip_w_next = ex_q.skip_w;
    wb_next        = me_skip_w_q;

    if (stall) begin
      me_next        = 4'b0001;
      me_skip_w_next = 1'b1;
    end

    if (flush) begin
      ex_next     = bubble();
      ex_imm_next = '0;
      state_next  = S_IDLE;
      latch_next  = bubble();
    end else if (!stall) begin
      ex_next     = bubble();
      ex_imm_next = '0;
      if (state_q == S_IMM) begin
        // The word is taken verbatim as the immediate, never decoded.
        if (instr_valid) begin
          ex_next     = latch_q;
          ex_imm_next = instr[IMM_W-1:0];
          state_next  = S_IDLE;
        end
      end else if (instr_valid) begin
        if (dec_two && (MULTIWORD != 0)) begin
          latch_next = dec;
          state_next = S_IMM;
        end else begin
          ex_next = dec;
          if (dec_two) begin
            ex_imm_next = imm_in;
          end
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Latched two-word bundle and the EX/MEM/WB control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q     <= bubble();
      ex_q        <= bubble();
      ex_imm_q    <= '0;
      me_q        <= 4'b0001;
      me_skip_w_q <= 1'b1;
      wb_q        <= 1'b1;
    end else begin
      latch_q     <= latch_next;
      ex_q        <= ex_next;
      ex_imm_q    <= ex_imm_next;
      me_q        <= me_next;
      me_skip_w_q <= me_skip_w_next;
      wb_q        <= wb_next;
    end
  end

  assign imm_pending = (state_q == S_IMM);
  assign id_srcs     = {ex_q.branch, ex_q.setc, ex_q.load};
  assign ex_cntrl    = {ex_q.func, ex_q.skip_e};
  assign ex_imm      = ex_imm_q;
  assign ex_imm_sel  = {ex_q.imm1, ex_q.imm2};
  assign me_cntrl    = me_q;
  assign wb_cntrl    = wb_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Testbench for ctrl_pipeline. Two instances share the same inputs:
// dut_mw (OPCODE_W=8, MULTIWORD=1) and dut_sc (OPCODE_W=7, MULTIWORD=0).
// Directed scenario tasks check fixed values; the random task compares both
// instances every cycle against a cycle-level reference model.
module tb_ctrl_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] imm_in;
  logic        stall;
  logic        flush;

  logic        a_pend, b_pend;
  logic [4:0]  a_id, b_id;
  logic [3:0]  a_ex, b_ex;
  logic [15:0] a_imm, b_imm;
  logic [1:0]  a_sel, b_sel;
  logic [3:0]  a_me, b_me;
  logic        a_wb, b_wb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pipeline #(.OPCODE_W(8), .IMM_W(16), .MULTIWORD(1)) dut_mw (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .imm_in(imm_in), .stall(stall), .flush(flush), .imm_pending(a_pend),
    .id_srcs(a_id), .ex_cntrl(a_ex), .ex_imm(a_imm), .ex_imm_sel(a_sel),
    .me_cntrl(a_me), .wb_cntrl(a_wb)
  );

  ctrl_pipeline #(.OPCODE_W(7), .IMM_W(16), .MULTIWORD(0)) dut_sc (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .imm_in(imm_in), .stall(stall), .flush(flush), .imm_pending(b_pend),
    .id_srcs(b_id), .ex_cntrl(b_ex), .ex_imm(b_imm), .ex_imm_sel(b_sel),
    .me_cntrl(b_me), .wb_cntrl(b_wb)
  );

  logic [32:0] obs0, obs1;
  assign obs0 = {a_id, a_ex, a_imm, a_sel, a_me, a_wb, a_pend};
  assign obs1 = {b_id, b_ex, b_imm, b_sel, b_me, b_wb, b_pend};

  // Reference model. A bundle is {id5, ex4, sel2, me4, wb1}; index 0 models
  // dut_mw and index 1 models dut_sc.
  localparam logic [15:0] BUB     = 16'b00000_0001_00_0001_1;
  localparam logic [32:0] BUB_OBS = {5'b0, 4'b0001, 16'h0, 2'b00, 4'b0001, 1'b1, 1'b0};

  logic [15:0] m_ex[2];
  logic [15:0] m_latch[2];
  logic [15:0] m_imm[2];
  logic [4:0]  m_mem[2];
  logic        m_wb[2];
  logic        m_pend[2];

  // Opcode table: returns the full bundle and whether a second word is needed.
  function automatic void ref_decode(input logic [15:0] w, input int opw,
                                     output logic [15:0] b, output bit two);
    logic [6:0] op;
    op  = w[6:0];
    b   = BUB;
    two = 1'b0;
    if (opw == 8 && w[7]) begin
      b = BUB;
    end else if (op == 7'h0C) begin
      b = 16'b00010_0001_00_0001_1;
    end else if (op[6:3] == 4'b0100) begin
      b = {5'b00000, op[2:0], 1'b0, 2'b00, 4'b0001, 1'b0};
    end else if (op == 7'h28) begin
      b = 16'b00000_0000_01_0001_0; two = 1'b1;
    end else if (op == 7'h30) begin
      b = 16'b00000_0001_00_0001_0;
    end else if (op == 7'h38) begin
      b = 16'b00000_0001_10_0001_0; two = 1'b1;
    end else if (op == 7'h40) begin
      b = 16'b00000_0001_00_1010_1;
    end else if (op == 7'h48) begin
      b = 16'b00000_0001_00_0100_0;
    end else if (op == 7'h50) begin
      b = 16'b00001_0000_01_0000_0; two = 1'b1;
    end else if (op == 7'h58) begin
      b = 16'b00000_0000_01_1000_1; two = 1'b1;
    end else if (op[6:4] == 3'b110) begin
      case (op[3:2])
        2'b00:   b = 16'b10100_0001_00_0001_1;
        2'b01:   b = 16'b11000_0001_00_0001_1;
        2'b10:   b = 16'b11100_0001_00_0001_1;
        default: b = 16'b10000_0001_00_0001_1;
      endcase
    end
  endfunction

  function automatic logic [32:0] exp_vec(input int k);
    return {m_ex[k][15:11], m_ex[k][10:7], m_imm[k], m_ex[k][6:5],
            m_mem[k][4:1], m_wb[k], m_pend[k]};
  endfunction

  task automatic model_step(input int k);
    logic [15:0] b;
    bit          two;
    bit          mw;
    mw = (k == 0);
    if (rst) begin
      m_ex[k] = BUB; m_latch[k] = BUB; m_imm[k] = '0;
      m_mem[k] = 5'b00011; m_wb[k] = 1'b1; m_pend[k] = 1'b0;
    end else begin
      m_wb[k]  = m_mem[k][0];
      m_mem[k] = stall ? 5'b00011 : m_ex[k][4:0];
      if (flush) begin
        m_ex[k] = BUB; m_imm[k] = '0; m_pend[k] = 1'b0;
      end else if (!stall) begin
        if (m_pend[k]) begin
          if (instr_valid) begin
            m_ex[k] = m_latch[k]; m_imm[k] = instr; m_pend[k] = 1'b0;
          end else begin
            m_ex[k] = BUB; m_imm[k] = '0;
          end
        end else if (instr_valid) begin
          ref_decode(instr, mw ? 8 : 7, b, two);
          if (two && mw) begin
            m_latch[k] = b; m_ex[k] = BUB; m_imm[k] = '0; m_pend[k] = 1'b1;
          end else begin
            m_ex[k] = b; m_imm[k] = two ? imm_in : 16'h0;
          end
        end else begin
          m_ex[k] = BUB; m_imm[k] = '0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] w,
                               input logic [15:0] imm, input logic st,
                               input logic fl);
    rst = 1'b0; instr_valid = v; instr = w; imm_in = imm; stall = st; flush = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = '0; imm_in = '0; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    checks++; if (obs0 !== BUB_OBS) begin errors++; $display("[TB] FAIL reset_mw: got %h expected %h", obs0, BUB_OBS); end
    checks++; if (obs1 !== BUB_OBS) begin errors++; $display("[TB] FAIL reset_sc: got %h expected %h", obs1, BUB_OBS); end
  endtask

  task automatic test_add();
    applyStimulus(1'b1, 16'h0020, 16'h0, 1'b0, 1'b0); tick();
    checks++; if (a_ex !== 4'b0000) begin errors++; $display("[TB] FAIL add_ex: got %b expected 0000", a_ex); end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
    checks++; if (a_me !== 4'b0001) begin errors++; $display("[TB] FAIL add_me: got %b expected 0001", a_me); end
    tick();
    checks++; if (a_wb !== 1'b0) begin errors++; $display("[TB] FAIL add_wb: got %b expected 0", a_wb); end
  endtask

  task automatic test_ldd();
    applyStimulus(1'b1, 16'h0050, 16'hA5A5, 1'b0, 1'b0); tick();
    checks++; if ({a_id, a_ex, a_pend} !== {5'b0, 4'b0001, 1'b1}) begin errors++; $display("[TB] FAIL ldd_first: got %b expected 0000000011", {a_id, a_ex, a_pend}); end
    checks++; if ({b_ex, b_imm, b_sel, b_pend} !== {4'b0000, 16'hA5A5, 2'b01, 1'b0}) begin errors++; $display("[TB] FAIL ldd_same_cycle: got %h expected %h", {b_ex, b_imm, b_sel, b_pend}, {4'b0000, 16'hA5A5, 2'b01, 1'b0}); end
    applyStimulus(1'b1, 16'h1234, 16'h0, 1'b0, 1'b0); tick();
    checks++; if ({a_ex, a_imm, a_sel, a_id, a_pend} !== {4'b0000, 16'h1234, 2'b01, 5'b00001, 1'b0}) begin errors++; $display("[TB] FAIL ldd_imm: got %h expected %h", {a_ex, a_imm, a_sel, a_id, a_pend}, {4'b0000, 16'h1234, 2'b01, 5'b00001, 1'b0}); end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
    checks++; if (a_me !== 4'b0000) begin errors++; $display("[TB] FAIL ldd_me: got %b expected 0000", a_me); end
  endtask

  task automatic test_ldm_gap();
    applyStimulus(1'b1, 16'h0038, 16'h0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'hBEEF, 16'h0, 1'b0, 1'b0); tick();
      checks++; if ({a_pend, a_ex, a_id} !== {1'b1, 4'b0001, 5'b0}) begin errors++; $display("[TB] FAIL ldm_wait%0d: got %b expected 1000100000", i, {a_pend, a_ex, a_id}); end
    end
    applyStimulus(1'b1, 16'hBEEF, 16'h0, 1'b0, 1'b0); tick();
    checks++; if ({a_imm, a_sel, a_ex, a_id, a_pend} !== {16'hBEEF, 2'b10, 4'b0001, 5'b0, 1'b0}) begin errors++; $display("[TB] FAIL ldm_imm: got %h expected %h", {a_imm, a_sel, a_ex, a_id, a_pend}, {16'hBEEF, 2'b10, 4'b0001, 5'b0, 1'b0}); end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 16'h0068, 16'h0, 1'b0, 1'b0); tick();
    checks++; if (a_id !== 5'b11100) begin errors++; $display("[TB] FAIL jc_id: got %b expected 11100", a_id); end
    applyStimulus(1'b1, 16'h0020, 16'h0, 1'b0, 1'b1); tick();
    checks++; if ({a_id, a_ex} !== {5'b0, 4'b0001}) begin errors++; $display("[TB] FAIL flush_ex: got %b expected 000000001", {a_id, a_ex}); end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
    checks++; if (a_ex !== 4'b0001) begin errors++; $display("[TB] FAIL flush_not_consumed: got %b expected 0001", a_ex); end
    applyStimulus(1'b1, 16'h0050, 16'h0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 16'h1234, 16'h0, 1'b0, 1'b1); tick();
    checks++; if ({a_pend, a_ex} !== {1'b0, 4'b0001}) begin errors++; $display("[TB] FAIL flush_imm: got %b expected 00001", {a_pend, a_ex}); end
    applyStimulus(1'b1, 16'h0020, 16'h0, 1'b0, 1'b0); tick();
    checks++; if ({a_ex, a_imm, a_sel} !== {4'b0000, 16'h0, 2'b00}) begin errors++; $display("[TB] FAIL flush_discard: got %h expected %h", {a_ex, a_imm, a_sel}, {4'b0000, 16'h0, 2'b00}); end
  endtask

  task automatic test_stall();
    applyStimulus(1'b1, 16'h0058, 16'h0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 16'h00AA, 16'h0, 1'b0, 1'b0); tick();
    checks++; if ({a_ex, a_imm, a_sel} !== {4'b0000, 16'h00AA, 2'b01}) begin errors++; $display("[TB] FAIL std_ex: got %h expected %h", {a_ex, a_imm, a_sel}, {4'b0000, 16'h00AA, 2'b01}); end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 16'h0020, 16'h0, 1'b1, 1'b0); tick();
      checks++; if ({a_ex, a_imm, a_sel, a_me} !== {4'b0000, 16'h00AA, 2'b01, 4'b0001}) begin errors++; $display("[TB] FAIL stall%0d: got %h expected %h", i, {a_ex, a_imm, a_sel, a_me}, {4'b0000, 16'h00AA, 2'b01, 4'b0001}); end
    end
    applyStimulus(1'b1, 16'h0020, 16'h0, 1'b0, 1'b0); tick();
    checks++; if ({a_me, a_imm, a_sel} !== {4'b1000, 16'h0, 2'b00}) begin errors++; $display("[TB] FAIL stall_release: got %h expected %h", {a_me, a_imm, a_sel}, {4'b1000, 16'h0, 2'b00}); end
  endtask

  task automatic test_reset_mid_imm();
    applyStimulus(1'b1, 16'h0050, 16'h0, 1'b0, 1'b0); tick();
    rst = 1'b1; tick();
    checks++; if (obs0 !== BUB_OBS) begin errors++; $display("[TB] FAIL rst_imm: got %h expected %h", obs0, BUB_OBS); end
    applyStimulus(1'b1, 16'h0005, 16'h0, 1'b0, 1'b0); tick();
    checks++; if ({a_id, a_ex, a_imm, a_sel, a_pend} !== {5'b0, 4'b0001, 16'h0, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL rst_w5: got %h expected %h", {a_id, a_ex, a_imm, a_sel, a_pend}, {5'b0, 4'b0001, 16'h0, 2'b00, 1'b0}); end
    applyStimulus(1'b1, 16'h0000, 16'h0, 1'b0, 1'b0); tick();
    checks++; if ({a_ex, a_imm, a_pend} !== {4'b0001, 16'h0, 1'b0}) begin errors++; $display("[TB] FAIL rst_w0: got %h expected %h", {a_ex, a_imm, a_pend}, {4'b0001, 16'h0, 1'b0}); end
  endtask

  task automatic test_unlisted();
    applyStimulus(1'b1, 16'h007F, 16'h0, 1'b0, 1'b0); tick();
    checks++; if ({a_id, a_ex, a_sel, a_pend} !== {5'b0, 4'b0001, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL op7f: got %b expected 000000001000", {a_id, a_ex, a_sel, a_pend}); end
    applyStimulus(1'b1, 16'h0080, 16'h0, 1'b0, 1'b0); tick();
    checks++; if ({a_id, a_ex, a_pend} !== {5'b0, 4'b0001, 1'b0}) begin errors++; $display("[TB] FAIL op80: got %b expected 0000000010", {a_id, a_ex, a_pend}); end
    applyStimulus(1'b1, 16'h00A0, 16'h0, 1'b0, 1'b0); tick();
    checks++; if ({a_ex, b_ex} !== {4'b0001, 4'b0000}) begin errors++; $display("[TB] FAIL opa0_width: got %b expected 00010000", {a_ex, b_ex}); end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(0, 3) != 0) begin
      case ($urandom_range(0, 11))
        0:  w = 16'h000C;
        1:  w = 16'h0014;
        2:  w = 16'h0020 + 16'($urandom_range(0, 15));
        3:  w = 16'h0030;
        4:  w = 16'h0038;
        5:  w = 16'h0040;
        6:  w = 16'h0048;
        7:  w = 16'h0050;
        8:  w = 16'h0058;
        9:  w = 16'h0060 + 16'($urandom_range(0, 15));
        10: w = 16'h0028;
        default: w = 16'h0080 | 16'($urandom_range(0, 127));
      endcase
    end
    return w;
  endfunction

  task automatic test_random();
    rst = 1'b1; tick();
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, rand_word(), 16'($urandom),
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8);
      rst = ($urandom_range(0, 99) == 0);
      tick();
      checks++; if (obs0 !== exp_vec(0)) begin errors++; $display("[TB] FAIL rand_mw cycle %0d: got %h expected %h", i, obs0, exp_vec(0)); end
      checks++; if (obs1 !== exp_vec(1)) begin errors++; $display("[TB] FAIL rand_sc cycle %0d: got %h expected %h", i, obs1, exp_vec(1)); end
    end
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; imm_in = '0; stall = 1'b0; flush = 1'b0;
    test_reset();
    test_add();
    test_ldd();
    test_ldm_gap();
    test_flush();
    test_stall();
    test_reset_mid_imm();
    test_unlisted();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
